matrix_slot_allocator: RTL and testbench

// Sits directly downstream of the UART input stage. It answers that stage's dimension

---
 rtl/matrix_slot_allocator.sv | 209 ++++++++++++++++++++
 tb/tb_matrix_slot_allocator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_allocator.sv
// Slot allocator between the UART input stage and the matrix RAM: grants slot base
// addresses, range-checks forwarded writes and keeps committed per-slot metadata.
module matrix_slot_allocator #(
    parameter int SLOTS       = 16,
    parameter int SLOT_WORDS  = 25,
    parameter int MAX_PER_DIM = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_active,
    input  logic              alloc_req,
    input  logic [2:0]        alloc_m,
    input  logic [2:0]        alloc_n,
    output logic [8:0]        alloc_base,
    output logic              alloc_ready,
    input  logic              wr_en,
    input  logic [8:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic              mem_we,
    output logic [8:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wr_oob,
    input  logic [3:0]        q_slot,
    output logic              q_valid,
    output logic [2:0]        q_m,
    output logic [2:0]        q_n,
    output logic [8:0]        q_base,
    output logic [4:0]        valid_count
);
    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GRANT, S_HOLD} state_t;
    state_t state, state_nx;

    logic [SLOTS-1:0] slot_valid, slot_pend, valid_nx, pend_nx;
    logic [2:0]       slot_m [SLOTS];
    logic [2:0]       slot_n [SLOTS];
    logic [15:0]      slot_stamp [SLOTS];
    logic [15:0]      seq;

    logic [2:0]       lat_m, lat_n;
    logic [IDX_W-1:0] scan_idx, same_idx, free_idx, old_idx, sel_idx;
    logic [CNT_W-1:0] same_cnt;
    logic             same_found, free_found, old_found, sel_ok, grant_fire;
    logic [15:0]      same_age, old_age, scan_age;
    logic             scan_v, scan_p, scan_same;

    logic [8:0]       grant_base;
    logic [9:0]       grant_lim;
    logic             have_grant, wr_hit;

    function automatic logic [8:0] slot_base(input logic [IDX_W-1:0] idx);
        return 9'(idx) * 9'(SLOT_WORDS);
    endfunction

    function automatic logic [4:0] popcount(input logic [SLOTS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < SLOTS; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    assign scan_v    = slot_valid[scan_idx];
    assign scan_p    = slot_pend[scan_idx];
    assign scan_same = (slot_m[scan_idx] == lat_m) && (slot_n[scan_idx] == lat_n);
    assign scan_age  = seq - slot_stamp[scan_idx];

    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        if (same_found && same_cnt >= CNT_W'(MAX_PER_DIM)) begin
            sel_ok  = 1'b1;
            sel_idx = same_idx;
        end else if (free_found) begin
            sel_ok  = 1'b1;
            sel_idx = free_idx;
        end else if (old_found) begin
            sel_ok  = 1'b1;
            sel_idx = old_idx;
        end
    end

    assign grant_fire = (state == S_GRANT) && sel_ok && in_active;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (alloc_req) state_nx = S_SCAN;
            S_SCAN:  if (scan_idx == IDX_W'(SLOTS - 1)) state_nx = S_GRANT;
            S_GRANT: state_nx = sel_ok ? S_HOLD : S_IDLE;
            S_HOLD:  if (!alloc_req) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (!in_active) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Commit validates slots pending before this cycle; the slot granted now stays pending.
    always_comb begin
        valid_nx = slot_valid;
        pend_nx  = slot_pend;
        if (commit) begin
            valid_nx = slot_valid | slot_pend;
            pend_nx  = '0;
        end
        if (grant_fire) begin
            valid_nx[sel_idx] = 1'b0;
            pend_nx[sel_idx]  = 1'b1;
        end
        if (!in_active) begin
            valid_nx = slot_valid;
            pend_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            slot_pend  <= '0;
            seq        <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_m[i]     <= '0;
                slot_n[i]     <= '0;
                slot_stamp[i] <= '0;
            end
        end else begin
            slot_valid <= valid_nx;
            slot_pend  <= pend_nx;
            if (grant_fire) begin
                slot_m[sel_idx]     <= lat_m;
                slot_n[sel_idx]     <= lat_n;
                slot_stamp[sel_idx] <= seq;
                seq                 <= seq + 16'd1;
            end
        end
    end

    // Scan trackers: strict '>' on age keeps ties on the lower index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_m <= '0; lat_n <= '0; scan_idx <= '0; same_cnt <= '0;
            same_found <= 1'b0; same_idx <= '0; same_age <= '0;
            free_found <= 1'b0; free_idx <= '0;
            old_found  <= 1'b0; old_idx  <= '0; old_age  <= '0;
        end else if (state == S_IDLE && alloc_req && in_active) begin
            lat_m <= alloc_m; lat_n <= alloc_n; scan_idx <= '0; same_cnt <= '0;
            same_found <= 1'b0; free_found <= 1'b0; old_found <= 1'b0;
        end else if (state == S_SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if ((scan_v || scan_p) && scan_same) same_cnt <= same_cnt + 1'b1;
            if (!scan_v && !scan_p && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
            if (scan_v && scan_same && (!same_found || scan_age > same_age)) begin
                same_found <= 1'b1;
                same_idx   <= scan_idx;
                same_age   <= scan_age;
            end
            if (scan_v && (!old_found || scan_age > old_age)) begin
                old_found <= 1'b1;
                old_idx   <= scan_idx;
                old_age   <= scan_age;
            end
        end
    end

    assign wr_hit = have_grant && (wr_addr >= grant_base) && ({1'b0, wr_addr} < grant_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ready <= 1'b0; alloc_base <= '0;
            grant_base  <= '0;   grant_lim  <= '0; have_grant <= 1'b0;
            mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0; wr_oob <= 1'b0;
            q_valid <= 1'b0; q_m <= '0; q_n <= '0; q_base <= '0; valid_count <= '0;
        end else begin
            alloc_ready <= grant_fire;
            if (grant_fire) begin
                alloc_base <= slot_base(sel_idx);
                grant_base <= slot_base(sel_idx);
                grant_lim  <= {1'b0, slot_base(sel_idx)} + 10'(lat_m) * 10'(lat_n);
                have_grant <= 1'b1;
            end else if (!in_active) begin
                have_grant <= 1'b0;
            end
            // Write stage: one-cycle registered forward to the RAM.
            mem_we <= wr_en && wr_hit;
            if (wr_en && wr_hit) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            if (grant_fire)            wr_oob <= 1'b0;
            else if (wr_en && !wr_hit) wr_oob <= 1'b1;
            // Query stage: committed state only.
            q_valid     <= slot_valid[IDX_W'(q_slot)];
            q_m         <= slot_valid[IDX_W'(q_slot)] ? slot_m[IDX_W'(q_slot)] : 3'd0;
            q_n         <= slot_valid[IDX_W'(q_slot)] ? slot_n[IDX_W'(q_slot)] : 3'd0;
            q_base      <= slot_base(IDX_W'(q_slot));
            valid_count <= popcount(slot_valid);
        end
    end
endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed self-checking bench for matrix_slot_allocator.
module tb_matrix_slot_allocator;
    logic        clk = 1'b0, rst_n = 1'b0, in_active = 1'b0, alloc_req = 1'b0;
    logic [2:0]  alloc_m = '0, alloc_n = '0;
    logic [8:0]  alloc_base;
    logic        alloc_ready;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        wr_oob;
    logic [3:0]  q_slot = '0;
    logic        q_valid;
    logic [2:0]  q_m, q_n;
    logic [8:0]  q_base;
    logic [4:0]  valid_count;

    int tests = 0;
    int fails = 0;

    matrix_slot_allocator dut (
        .clk(clk), .rst_n(rst_n), .in_active(in_active), .alloc_req(alloc_req),
        .alloc_m(alloc_m), .alloc_n(alloc_n), .alloc_base(alloc_base), .alloc_ready(alloc_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wr_oob(wr_oob),
        .q_slot(q_slot), .q_valid(q_valid), .q_m(q_m), .q_n(q_n), .q_base(q_base),
        .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_active = 1'b0; alloc_req = 1'b0; wr_en = 1'b0; commit = 1'b0; q_slot = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        in_active = 1'b1;
        tick();
    endtask

    // Returns the number of edges from request to visible alloc_ready, or -1 if none in 40.
    task automatic grant(input logic [2:0] m, input logic [2:0] n, input bit hold,
                         output int cyc, output logic [8:0] base);
        bit got;
        got = 1'b0;
        alloc_m = m; alloc_n = n; alloc_req = 1'b1;
        cyc = 0; base = '1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            cyc++;
            if (alloc_ready) begin
                got  = 1'b1;
                base = alloc_base;
            end
        end
        if (!got) cyc = -1;
        if (!hold) begin
            alloc_req = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic write(input logic [8:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [8:0] base;
        int pulses;

        // Reset state
        rst_n = 1'b0;
        tick();
        check("rst_alloc_ready", 32'(alloc_ready), 0);
        check("rst_alloc_base", 32'(alloc_base), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_wr_oob", 32'(wr_oob), 0);
        check("rst_q_valid", 32'(q_valid), 0);
        check("rst_valid_count", 32'(valid_count), 0);
        do_reset();

        // First 2x3 grant: latency and base, writes 0..5, commit, query
        grant(3'd2, 3'd3, 1'b0, cyc, base);
        check("a_latency", 32'(cyc), 18);
        check("a_base", 32'(base), 0);
        check("a_ready_drops", 32'(alloc_ready), 0);
        for (int i = 0; i < 6; i++) begin
            write(9'(i), 32'(100 + i));
            check("a_mem_we", 32'(mem_we), 1);
            check("a_mem_addr", 32'(mem_addr), 32'(i));
            check("a_mem_wdata", mem_wdata, 32'(100 + i));
        end
        tick();
        check("a_mem_we_idle", 32'(mem_we), 0);
        check("a_no_oob", 32'(wr_oob), 0);
        pulse_commit();
        q_slot = 4'd0;
        tick();
        check("a_q_valid", 32'(q_valid), 1);
        check("a_q_m", 32'(q_m), 2);
        check("a_q_n", 32'(q_n), 3);
        check("a_q_base", 32'(q_base), 0);
        check("a_valid_count", 32'(valid_count), 1);

        // Second 2x3 goes to free slot 1; out-of-range write sets sticky oob
        grant(3'd2, 3'd3, 1'b0, cyc, base);
        check("b_base", 32'(base), 25);
        write(9'd31, 32'hdead);
        check("b_oob_we", 32'(mem_we), 0);
        check("b_oob_flag", 32'(wr_oob), 1);
        write(9'd30, 32'hbeef);
        check("b_inrange_we", 32'(mem_we), 1);
        check("b_oob_sticky", 32'(wr_oob), 1);
        pulse_commit();
        // Third 2x3 evicts the older same-dims slot 0
        grant(3'd2, 3'd3, 1'b0, cyc, base);
        check("b_evict_base", 32'(base), 0);
        check("b_oob_cleared", 32'(wr_oob), 0);
        check("b_count_after_evict", 32'(valid_count), 1);
        q_slot = 4'd0;
        tick();
        check("b_evicted_invalid", 32'(q_valid), 0);
        check("b_evicted_q_m", 32'(q_m), 0);
        q_slot = 4'd1;
        tick();
        check("b_slot1_valid", 32'(q_valid), 1);
        check("b_slot1_base", 32'(q_base), 25);
        pulse_commit();
        tick();
        check("b_count_after_commit", 32'(valid_count), 2);

        // Two 3x3 grants then a single commit
        do_reset();
        grant(3'd3, 3'd3, 1'b0, cyc, base);
        check("c_base0", 32'(base), 0);
        grant(3'd3, 3'd3, 1'b0, cyc, base);
        check("c_base1", 32'(base), 25);
        pulse_commit();
        q_slot = 4'd0;
        tick();
        check("c_q0_valid", 32'(q_valid), 1);
        check("c_q0_m", 32'(q_m), 3);
        q_slot = 4'd1;
        tick();
        check("c_q1_valid", 32'(q_valid), 1);
        check("c_q1_n", 32'(q_n), 3);
        check("c_valid_count", 32'(valid_count), 2);

        // Abort after grant: slot freed, early write in new session rejected, slot reused
        do_reset();
        grant(3'd2, 3'd2, 1'b0, cyc, base);
        check("d_base", 32'(base), 0);
        in_active = 1'b0;
        tick();
        in_active = 1'b1;
        write(9'd0, 32'h1234);
        check("d_pregrant_we", 32'(mem_we), 0);
        check("d_pregrant_oob", 32'(wr_oob), 1);
        q_slot = 4'd0;
        tick();
        check("d_count", 32'(valid_count), 0);
        check("d_q_invalid", 32'(q_valid), 0);
        grant(3'd4, 3'd4, 1'b0, cyc, base);
        check("d_reuse_latency", 32'(cyc), 18);
        check("d_reuse_base", 32'(base), 0);
        check("d_oob_cleared", 32'(wr_oob), 0);
        pulse_commit();
        tick();
        check("d_reuse_m", 32'(q_m), 4);

        // Fill 16 slots with distinct dims, then new dims evict oldest; held request grants once
        do_reset();
        for (int k = 0; k < 16; k++) begin
            grant(3'(k / 4 + 1), 3'(k % 4 + 1), 1'b0, cyc, base);
            check("e_fill_base", 32'(base), 32'(k * 25));
        end
        pulse_commit();
        tick();
        check("e_full_count", 32'(valid_count), 16);
        grant(3'd5, 3'd5, 1'b1, cyc, base);
        check("e_oldest_base", 32'(base), 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (alloc_ready) pulses++;
        end
        check("e_no_regrant", 32'(pulses), 0);
        alloc_req = 1'b0;
        tick();
        check("e_count_after_evict", 32'(valid_count), 15);
        q_slot = 4'd0;
        tick();
        check("e_slot0_pending", 32'(q_valid), 0);

        // All slots pending: request must never be granted
        do_reset();
        for (int k = 0; k < 16; k++) grant(3'(k / 4 + 1), 3'(k % 4 + 1), 1'b0, cyc, base);
        grant(3'd1, 3'd1, 1'b0, cyc, base);
        check("f_no_grant", 32'(cyc), -1);
        pulse_commit();
        tick();
        check("f_count", 32'(valid_count), 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
